// File: rtl/ps_pkg.sv
// Shared types and helpers for the PacketStream arbiter and anything that
// needs to size a channel index the same way.
package ps_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } ps_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_arbiter_if.sv
// PacketStream bundle for the arbiter: COUNT inbound channels, one outbound
// stream and the index of the channel currently driving it.
interface ps_arbiter_if
  import ps_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
);

  localparam int SW = sel_w(COUNT);

  logic [COUNT*WIDTH-1:0] i_dat;
  logic [COUNT-1:0]       i_val;
  logic [COUNT-1:0]       i_eop;
  logic [COUNT-1:0]       i_rdy;
  logic [WIDTH-1:0]       o_dat;
  logic                   o_val;
  logic                   o_eop;
  logic                   o_rdy;
  logic [SW-1:0]          o_sel;

  // master: the arbiter itself; slave: sources and sink around it
  modport master (
    input  i_dat, i_val, i_eop, o_rdy,
    output i_rdy, o_dat, o_val, o_eop, o_sel
  );

  modport slave (
    output i_dat, i_val, i_eop, o_rdy,
    input  i_rdy, o_dat, o_val, o_eop, o_sel
  );

endinterface

// File: rtl/rr_prio_encoder.sv
// Rotating priority encoder: first set bit of req searching start, start+1, ...
// wrapping at COUNT (works for non-power-of-two COUNT).
module rr_prio_encoder #(
  parameter int COUNT = 4,
  parameter int IDX_W = 2
) (
  input  logic [COUNT-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Lowest request overall covers the wrapped case; lowest request at or
  // above start overrides it when one exists.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = COUNT - 1; k >= 0; k--) begin
      if (req[k]) begin
        found = 1'b1;
        idx   = IDX_W'(k);
      end
    end
    for (int k = COUNT - 1; k >= 0; k--) begin
      if (req[k] && (IDX_W'(k) >= start)) begin
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/ps_arbiter.sv
// Packet-atomic round-robin arbiter merging COUNT PacketStream channels into one.
//   state | meaning
//   IDLE  | no owner; candidate from rotating search drives output combinationally
//   LOCK  | channel sel_reg owns the output until its eop word transfers
module ps_arbiter
  import ps_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input logic          clk,
  input logic          rst,
  ps_arbiter_if.master bus
);

  localparam int SW = sel_w(COUNT);

  generate
    if (COUNT == 1) begin : g_pass
      assign bus.o_dat = bus.i_dat;
      assign bus.o_val = bus.i_val[0];
      assign bus.o_eop = bus.i_eop[0];
      assign bus.i_rdy = bus.o_rdy;
      assign bus.o_sel = '0;
    end else begin : g_arb
      ps_state_e        state;
      logic [SW-1:0]    ptr;
      logic [SW-1:0]    sel_reg;
      logic [SW-1:0]    cand;
      logic [SW-1:0]    sel;
      logic             found;
      logic             act;
      logic             val_m;
      logic             eop_m;
      logic             eop_xfer;
      logic [WIDTH-1:0] dat_m;
      logic [COUNT-1:0] rdy_m;

      rr_prio_encoder #(
        .COUNT (COUNT),
        .IDX_W (SW)
      ) u_prio (
        .req   (bus.i_val),
        .start (ptr),
        .found (found),
        .idx   (cand)
      );

      always_comb begin
        sel   = (state == LOCK) ? sel_reg : cand;
        act   = (state == LOCK) || found;
        dat_m = '0;
        val_m = 1'b0;
        eop_m = 1'b0;
        rdy_m = '0;
        for (int k = 0; k < COUNT; k++) begin
          if (sel == SW'(k)) begin
            dat_m    = bus.i_dat[k*WIDTH +: WIDTH];
            val_m    = act && bus.i_val[k];
            eop_m    = act && bus.i_eop[k];
            rdy_m[k] = act && bus.o_rdy;
          end
        end
        eop_xfer = val_m && eop_m && bus.o_rdy;
      end

      assign bus.o_dat = dat_m;
      assign bus.o_val = val_m;
      assign bus.o_eop = eop_m;
      assign bus.i_rdy = rdy_m;
      assign bus.o_sel = sel;

      always_ff @(posedge clk) begin
        if (rst) begin
          state   <= IDLE;
          ptr     <= '0;
          sel_reg <= '0;
        end else begin
          unique case (state)
            IDLE: begin
              if (found) begin
                if (eop_xfer) begin
                  ptr <= (cand == SW'(COUNT - 1)) ? '0 : cand + 1'b1;
                end else begin
                  state   <= LOCK;
                  sel_reg <= cand;
                end
              end
            end
            LOCK: begin
              if (eop_xfer) begin
                state <= IDLE;
                ptr   <= (sel_reg == SW'(COUNT - 1)) ? '0 : sel_reg + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ps_arbiter.sv
// Directed bench for ps_arbiter: COUNT=4, COUNT=3 and COUNT=1 instances.
module tb_ps_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ps_arbiter_if #(.WIDTH(8), .COUNT(4)) bus4 ();
  ps_arbiter_if #(.WIDTH(8), .COUNT(3)) bus3 ();
  ps_arbiter_if #(.WIDTH(8), .COUNT(1)) bus1 ();

  ps_arbiter #(.WIDTH(8), .COUNT(4)) u_arb4 (.clk(clk), .rst(rst), .bus(bus4));
  ps_arbiter #(.WIDTH(8), .COUNT(3)) u_arb3 (.clk(clk), .rst(rst), .bus(bus3));
  ps_arbiter #(.WIDTH(8), .COUNT(1)) u_arb1 (.clk(clk), .rst(rst), .bus(bus1));

  // per-channel packet sources for the COUNT=4 instance
  int         n4[4];
  int         len4[4];
  logic [7:0] base4[4];

  task automatic src_init(input int l0, l1, l2, l3,
                          input logic [7:0] b0, b1, b2, b3);
    n4    = '{0, 0, 0, 0};
    len4  = '{l0, l1, l2, l3};
    base4 = '{b0, b1, b2, b3};
  endtask

  task automatic drive4(input logic [3:0] en, input logic rdy);
    for (int k = 0; k < 4; k++) begin
      if (en[k] && (n4[k] < len4[k])) begin
        bus4.i_val[k]         = 1'b1;
        bus4.i_dat[k*8 +: 8]  = base4[k] + 8'(n4[k]);
        bus4.i_eop[k]         = (n4[k] == len4[k] - 1);
      end else begin
        bus4.i_val[k]         = 1'b0;
        bus4.i_dat[k*8 +: 8]  = 8'h00;
        bus4.i_eop[k]         = 1'b0;
      end
    end
    bus4.o_rdy = rdy;
  endtask

  task automatic step4();
    logic [3:0] taken;
    taken = bus4.i_rdy & bus4.i_val;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (taken[k]) n4[k]++;
  endtask

  // packed view: {o_val, o_eop, o_sel[1:0], o_dat[7:0], i_rdy[3:0]}
  task automatic test_reset();
    rst = 1'b1;
    src_init(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    drive4(4'b0000, 1'b1);
    bus3.i_val = '0; bus3.i_eop = '0; bus3.i_dat = '0; bus3.o_rdy = 1'b1;
    bus1.i_val = '0; bus1.i_eop = '0; bus1.i_dat = '0; bus1.o_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus4.o_val !== 1'b0) begin
      errors++; $display("FAIL reset4_val got %b exp 0", bus4.o_val);
    end
    checks++;
    if (bus4.i_rdy !== 4'b0000) begin
      errors++; $display("FAIL reset4_rdy got %b exp 0000", bus4.i_rdy);
    end
    checks++;
    if (bus3.o_val !== 1'b0) begin
      errors++; $display("FAIL reset3_val got %b exp 0", bus3.o_val);
    end
    checks++;
    if (bus3.i_rdy !== 3'b000) begin
      errors++; $display("FAIL reset3_rdy got %b exp 000", bus3.i_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_t[6];
    logic [15:0] got;
    exp_t = '{{1'b1, 1'b0, 2'd0, 8'h01, 4'b0001},
              {1'b1, 1'b0, 2'd0, 8'h02, 4'b0001},
              {1'b1, 1'b1, 2'd0, 8'h03, 4'b0001},
              {1'b1, 1'b0, 2'd2, 8'h21, 4'b0100},
              {1'b1, 1'b0, 2'd2, 8'h22, 4'b0100},
              {1'b1, 1'b1, 2'd2, 8'h23, 4'b0100}};
    src_init(3, 0, 3, 0, 8'h01, 8'h00, 8'h21, 8'h00);
    for (int c = 0; c < 6; c++) begin
      drive4(4'b0101, 1'b1);
      #1;
      got = {bus4.o_val, bus4.o_eop, bus4.o_sel, bus4.o_dat, bus4.i_rdy};
      checks++;
      if (got !== exp_t[c]) begin
        errors++; $display("FAIL simultaneous cyc%0d got %h exp %h", c, got, exp_t[c]);
      end
      step4();
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_t[7];
    logic [15:0] got;
    logic        hit;
    exp_t = '{{1'b1, 1'b0, 2'd1, 8'hA1, 4'b0000},
              {1'b1, 1'b0, 2'd1, 8'hA1, 4'b0000},
              {1'b1, 1'b0, 2'd1, 8'hA1, 4'b0000},
              {1'b1, 1'b0, 2'd1, 8'hA1, 4'b0010},
              {1'b1, 1'b1, 2'd1, 8'hA2, 4'b0010},
              {1'b1, 1'b1, 2'd3, 8'h31, 4'b1000},
              {1'b0, 1'b0, 2'd0, 8'h00, 4'b0000}};
    src_init(0, 2, 0, 1, 8'h00, 8'hA1, 8'h00, 8'h31);
    for (int c = 0; c < 7; c++) begin
      drive4((c == 0) ? 4'b0010 : 4'b1010, (c >= 3));
      #1;
      got = {bus4.o_val, bus4.o_eop, bus4.o_sel, bus4.o_dat, bus4.i_rdy};
      hit = exp_t[c][15] ? (got !== exp_t[c])
                         : ({got[15], got[3:0]} !== {exp_t[c][15], exp_t[c][3:0]});
      checks++;
      if (hit) begin
        errors++; $display("FAIL stall cyc%0d got %h exp %h", c, got, exp_t[c]);
      end
      step4();
    end
  endtask

  task automatic test_drop();
    logic [15:0] exp_t[7];
    logic [15:0] got;
    logic        hit;
    exp_t = '{{1'b1, 1'b0, 2'd0, 8'h51, 4'b0001},
              {1'b0, 1'b0, 2'd0, 8'h00, 4'b0001},
              {1'b0, 1'b0, 2'd0, 8'h00, 4'b0001},
              {1'b1, 1'b0, 2'd0, 8'h52, 4'b0001},
              {1'b1, 1'b1, 2'd0, 8'h53, 4'b0001},
              {1'b1, 1'b1, 2'd1, 8'h61, 4'b0010},
              {1'b0, 1'b0, 2'd0, 8'h00, 4'b0000}};
    src_init(3, 1, 0, 0, 8'h51, 8'h61, 8'h00, 8'h00);
    for (int c = 0; c < 7; c++) begin
      drive4((c == 1 || c == 2) ? 4'b0010 : 4'b0011, 1'b1);
      #1;
      got = {bus4.o_val, bus4.o_eop, bus4.o_sel, bus4.o_dat, bus4.i_rdy};
      hit = exp_t[c][15] ? (got !== exp_t[c])
                         : ({got[15], got[3:0]} !== {exp_t[c][15], exp_t[c][3:0]});
      checks++;
      if (hit) begin
        errors++; $display("FAIL drop cyc%0d got %h exp %h", c, got, exp_t[c]);
      end
      step4();
    end
  endtask

  // ptr is 2 on entry, so only a working reset lets ch1 win afterwards
  task automatic test_reset_mid();
    logic [15:0] exp_t[4];
    logic [15:0] got;
    exp_t = '{{1'b1, 1'b0, 2'd2, 8'h71, 4'b0100},
              {1'b1, 1'b0, 2'd2, 8'h72, 4'b0100},
              {1'b1, 1'b1, 2'd1, 8'h81, 4'b0010},
              {1'b1, 1'b0, 2'd2, 8'h73, 4'b0100}};
    src_init(0, 1, 4, 0, 8'h00, 8'h81, 8'h71, 8'h00);
    for (int c = 0; c < 4; c++) begin
      rst = (c == 1);
      drive4((c >= 2) ? 4'b0110 : 4'b0100, 1'b1);
      #1;
      got = {bus4.o_val, bus4.o_eop, bus4.o_sel, bus4.o_dat, bus4.i_rdy};
      checks++;
      if (got !== exp_t[c]) begin
        errors++; $display("FAIL reset_mid cyc%0d got %h exp %h", c, got, exp_t[c]);
      end
      step4();
    end
    rst = 1'b0;
    drive4(4'b0000, 1'b0);
  endtask

  // packed view: {o_val, o_eop, o_sel[1:0], o_dat[7:0], i_rdy[2:0]}
  task automatic test_count3();
    logic [14:0] exp_t[6];
    logic [14:0] got;
    exp_t = '{{1'b1, 1'b1, 2'd0, 8'hC0, 3'b001},
              {1'b1, 1'b1, 2'd1, 8'hC1, 3'b010},
              {1'b1, 1'b1, 2'd2, 8'hC2, 3'b100},
              {1'b1, 1'b1, 2'd0, 8'hC0, 3'b001},
              {1'b1, 1'b1, 2'd1, 8'hC1, 3'b010},
              {1'b1, 1'b1, 2'd2, 8'hC2, 3'b100}};
    bus3.i_dat = {8'hC2, 8'hC1, 8'hC0};
    bus3.i_val = 3'b111;
    bus3.i_eop = 3'b111;
    bus3.o_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      got = {bus3.o_val, bus3.o_eop, bus3.o_sel, bus3.o_dat, bus3.i_rdy};
      checks++;
      if (got !== exp_t[c]) begin
        errors++; $display("FAIL count3 cyc%0d got %h exp %h", c, got, exp_t[c]);
      end
      @(posedge clk);
      #1;
    end
    bus3.i_val = '0;
  endtask

  // packed view: {o_dat, o_val, o_eop, i_rdy, o_sel}
  task automatic test_count1();
    logic [7:0]  d;
    logic        v, e, r;
    logic [11:0] got;
    logic [11:0] exp_v;
    for (int c = 0; c < 16; c++) begin
      d = 8'($urandom);
      v = 1'($urandom_range(1));
      e = 1'($urandom_range(1));
      r = 1'($urandom_range(1));
      bus1.i_dat = d;
      bus1.i_val = v;
      bus1.i_eop = e;
      bus1.o_rdy = r;
      #1;
      got   = {bus1.o_dat, bus1.o_val, bus1.o_eop, bus1.i_rdy, bus1.o_sel};
      exp_v = {d, v, e, r, 1'b0};
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL count1 cyc%0d got %h exp %h", c, got, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_simultaneous();
    test_stall();
    test_drop();
    test_reset_mid();
    test_count3();
    test_count1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps_arbiter.md
PS_ARBITER -- requirements
Module: ps_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, stream data width in bits; SHALL be >= 1.
REQ-002 Parameter COUNT, default 4, number of inbound PacketStream channels; SHALL be >= 1.
REQ-003 Port rst  input  1  reset; one clock, synchronous to clk, active-high.
REQ-004 Port clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 Port i_dat  input  COUNT*WIDTH  inbound data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 Port i_val  input  COUNT  per-channel valid.
REQ-007 Port i_eop  input  COUNT  per-channel end-of-packet.
REQ-008 Port i_rdy  output  COUNT  per-channel ready.
REQ-009 Port o_dat  output  WIDTH  outbound data.
REQ-010 Port o_val  output  1  outbound valid.
REQ-011 Port o_eop  output  1  outbound end-of-packet.
REQ-012 Port o_rdy  input  1  outbound ready.
REQ-013 Port o_sel  output  max(1,$clog2(COUNT))  index of the channel currently driving the output; meaningful only while o_val=1.

Function
REQ-014 Transfer on any stream SHALL occur exactly when its val and rdy are both 1 in the same cycle.
REQ-015 The block SHALL be packet-atomic: once a channel's first word is presented, no other channel's word SHALL appear on the output until that channel's word with eop=1 is transferred.
REQ-016 FSM states: IDLE (no channel owns the output) and LOCK (channel sel_reg owns it).
REQ-017 IDLE: candidate = first channel with i_val=1, searching ptr, ptr+1, ... wrapping modulo COUNT; if none, o_val=0 and all i_rdy=0.
REQ-018 IDLE with a candidate c: output driven from c combinationally (zero latency); o_sel=c.
REQ-019 IDLE -> LOCK with sel_reg=c when c is not transferred, or is transferred with eop=0.
REQ-020 IDLE, c transferred with eop=1 (single-word packet): stay IDLE, ptr <= (c+1) mod COUNT.
REQ-021 LOCK: o_dat/o_val/o_eop SHALL mirror channel sel_reg; o_sel=sel_reg; other channels' inputs SHALL be ignored.
REQ-022 LOCK -> IDLE when the sel_reg word with eop=1 is transferred; ptr <= (sel_reg+1) mod COUNT in the same cycle.
REQ-023 i_rdy[k] SHALL equal o_rdy when k is the selected channel (IDLE candidate or LOCK sel_reg), else 0.
REQ-024 Between words in LOCK the selected channel MAY deassert i_val; o_val follows it and ownership is retained.
REQ-025 ptr SHALL change only on an eop transfer; a stalled or partial packet SHALL NOT move it.
REQ-026 Back-to-back packets from different channels SHALL proceed with no idle cycle (eop transfer in cycle n, next channel's word transferable in cycle n+1).
REQ-027 COUNT=1: pure pass-through, o_sel=0, no FSM state required.

Reset
REQ-028 While rst=1 at a clock edge: state <= IDLE, ptr <= 0, sel_reg <= 0.
REQ-029 Reset mid-packet SHALL abandon ownership; after reset, arbitration restarts from channel 0.
REQ-030 Outputs remain combinational from state and inputs; with no i_val asserted after reset, o_val=0 and i_rdy=0.

Structure
REQ-031 The state enumeration (IDLE, LOCK) SHALL be a typedef in the shared package ps_pkg.
REQ-032 The rotating priority search SHALL be a separate sub-module rr_prio_encoder (inputs: request vector, start pointer; outputs: found flag, index), reusable elsewhere.
REQ-033 The ptr and sel_reg width SHALL be max(1,$clog2(COUNT)); modulo wrap is required for non-power-of-two COUNT.

Verification
REQ-034 COUNT=4; ch0 and ch2 each send 3-word packets simultaneously, o_rdy=1 -> ch0 words 0..2 in cycles 0..2, then ch2 words in cycles 3..5 with no gap; o_sel 0,0,0,2,2,2.
REQ-035 ch1 sends A1,A2(eop), ch3 asserts val during A1; o_rdy=0 for 3 cycles during A1 -> o_dat holds A1, o_sel holds 1, i_rdy all 0; ch3 starts only after A2 transfers.
REQ-036 COUNT=3, all channels continuously send 1-word packets -> grant order 0,1,2,0,1,2 (wrap on non-power-of-two).
REQ-037 ch2 mid-packet (1 of 4 words sent), rst=1 for one cycle, then ch1 and ch2 valid -> ch1 granted first (ptr=0 search).
REQ-038 Locked ch0 drops i_val for 2 cycles mid-packet while ch1 valid -> o_val=0 for those 2 cycles, ch1 not granted until ch0 eop.
REQ-039 COUNT=1, random val/eop/o_rdy -> outputs identical to inputs, i_rdy=o_rdy every cycle.
